mac_mgnt_sched: RTL and testbench

Management request scheduler between the single host-side management port (SPI register bridge) and the NPORT per-port MAC statistics controllers. It accepts one host register transaction at a time, routes it to the addressed port, or broadcasts it to all ports, then assembles the port's 4-byte serial read response into a 32-bit word. It also enforces inter-request spacing and a response timeout, so a dead or busy port cannot hang the management bus.

---
 rtl/mac_mgnt_sched.sv | 116 +++++++++++
 tb/tb_mac_mgnt_sched.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mac_mgnt_sched.sv
// mac_mgnt_sched: routes one host management transaction at a time to a MAC port (or all ports),
// assembles the 4-byte read reply, and bounds every transaction with a write gap or read timeout.
module mac_mgnt_sched #(
  parameter int NPORT  = 8,
  parameter int PW     = 4,
  parameter int WR_GAP = 4,
  parameter int TO_CYC = 64
) (
  input  logic                 clk_if,
  input  logic                 rst_if_n,
  input  logic                 host_req_valid,
  output logic                 host_req_ready,
  input  logic                 host_req_wr,
  input  logic [PW-1:0]        host_req_port,
  input  logic [7:0]           host_req_addr,
  output logic                 host_resp_valid,
  output logic [31:0]          host_resp_data,
  output logic                 host_resp_err,
  output logic [NPORT-1:0]     port_req_valid,
  output logic                 port_req_wr,
  output logic [7:0]           port_req_addr,
  input  logic [NPORT-1:0]     port_resp_valid,
  input  logic [8*NPORT-1:0]   port_resp_data
);
  typedef enum logic [2:0] {IDLE, CHECK, ISSUE, WAIT_WR, WAIT_RD, COLLECT, DRAIN, RESP} state_t;
  localparam logic [PW-1:0] NP  = PW'(NPORT);
  localparam logic [7:0]    GAP = 8'(WR_GAP);
  localparam logic [7:0]    TO  = 8'(TO_CYC);
  state_t state, state_n;
  logic wr, err_n, sel_v, bcast, timeout;
  logic [PW-1:0] port;
  logic [7:0] addr, cnt, sel_b;
  logic [1:0] bcnt;
  logic [31:0] sh;
  logic [NPORT-1:0] mask;
  assign bcast   = port == '1;
  assign timeout = cnt >= TO;
  always_comb begin
    sel_v = 1'b0;
    sel_b = '0;
    mask  = '0;
    for (int k = 0; k < NPORT; k++) begin
      mask[k] = bcast || port == PW'(k);
      if (port == PW'(k)) begin
        sel_v = port_resp_valid[k];
        sel_b = port_resp_data[8*k +: 8];
      end
    end
  end
  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    case (state)
      IDLE:    state_n = host_req_valid ? CHECK : IDLE;
      CHECK: begin
        err_n   = !(port < NP || (bcast && wr));
        state_n = err_n ? RESP : ISSUE;
      end
      ISSUE:   state_n = wr ? WAIT_WR : WAIT_RD;
      WAIT_WR: state_n = cnt >= GAP ? RESP : WAIT_WR;
      WAIT_RD: begin
        err_n   = timeout;
        state_n = timeout ? RESP : sel_v ? COLLECT : WAIT_RD;
      end
      COLLECT: begin
        err_n   = !sel_v;
        state_n = !sel_v ? RESP : bcnt == 2'd3 ? DRAIN : COLLECT;
      end
      DRAIN: begin
        err_n   = sel_v && timeout;
        state_n = (!sel_v || timeout) ? RESP : DRAIN;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_if or negedge rst_if_n) begin
    if (!rst_if_n) begin
      state           <= IDLE;
      host_req_ready  <= 1'b1;
      host_resp_valid <= 1'b0;
      host_resp_data  <= '0;
      host_resp_err   <= 1'b0;
      port_req_valid  <= '0;
      port_req_wr     <= 1'b0;
      port_req_addr   <= '0;
      wr              <= 1'b0;
      port            <= '0;
      addr            <= '0;
      cnt             <= '0;
      bcnt            <= '0;
      sh              <= '0;
    end else begin
      state           <= state_n;
      host_req_ready  <= state_n == IDLE;
      host_resp_valid <= state_n == RESP;
      host_resp_err   <= err_n;
      host_resp_data  <= (state == DRAIN && state_n == RESP && !err_n) ? sh : '0;
      port_req_valid  <= state_n == ISSUE ? mask : '0;
      if (state == IDLE && host_req_valid) begin
        wr   <= host_req_wr;
        port <= host_req_port;
        addr <= host_req_addr;
      end
      if (state_n == ISSUE) begin
        port_req_wr   <= wr;
        port_req_addr <= addr;
      end
      // counter zero in the ISSUE cycle so both write gap and timeout are measured from issue
      cnt <= state_n == ISSUE ? '0 : cnt + {7'd0, cnt != 8'hFF};
      if ((state == WAIT_RD || state == COLLECT) && sel_v) begin
        sh   <= {sh[23:0], sel_b};
        bcnt <= state == WAIT_RD ? 2'd1 : bcnt + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_mac_mgnt_sched.sv
// tb_mac_mgnt_sched: directed transactions checked every cycle against a per-transaction timing/data model.
module tb_mac_mgnt_sched;
  localparam int WR_GAP = 4;
  localparam int TO_CYC = 64;
  logic        clk_if = 1'b0, rst_if_n = 1'b0;
  logic        host_req_valid = 1'b0, host_req_wr = 1'b0;
  logic [3:0]  host_req_port = '0;
  logic [7:0]  host_req_addr = '0;
  logic        host_req_ready, host_resp_valid, host_resp_err, port_req_wr;
  logic [31:0] host_resp_data;
  logic [7:0]  port_req_valid, port_req_addr;
  logic [7:0]  port_resp_valid = '0;
  logic [63:0] port_resp_data = '0;
  int cyc = 0, errors = 0, checks = 0;
  bit active = 1'b0;
  int t_acc = 0, t_resp = 0, seen_cyc = -1, t0;
  logic [31:0] e_data, seen_data;
  logic e_err, e_strobe, e_wr, seen_err, ev, st_now;
  logic [7:0] e_mask, e_addr;

  mac_mgnt_sched dut (
    .clk_if(clk_if), .rst_if_n(rst_if_n),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_wr(host_req_wr), .host_req_port(host_req_port), .host_req_addr(host_req_addr),
    .host_resp_valid(host_resp_valid), .host_resp_data(host_resp_data), .host_resp_err(host_resp_err),
    .port_req_valid(port_req_valid), .port_req_wr(port_req_wr), .port_req_addr(port_req_addr),
    .port_resp_valid(port_resp_valid), .port_resp_data(port_resp_data)
  );

  always #5 clk_if = ~clk_if;
  always @(posedge clk_if) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, cyc);
    end
  endtask

  always @(negedge clk_if) begin
    ev     = active && cyc == t_resp;
    st_now = active && e_strobe && cyc == t_acc + 2;
    chk("resp_valid", {31'd0, host_resp_valid}, {31'd0, ev});
    if (ev) begin
      chk("resp_data", host_resp_data, e_data);
      chk("resp_err", {31'd0, host_resp_err}, {31'd0, e_err});
    end
    chk("req_valid", {24'd0, port_req_valid}, st_now ? {24'd0, e_mask} : 32'd0);
    if (st_now) begin
      chk("req_wr", {31'd0, port_req_wr}, {31'd0, e_wr});
      chk("req_addr", {24'd0, port_req_addr}, {24'd0, e_addr});
    end
    chk("req_ready", {31'd0, host_req_ready}, {31'd0, !(active && cyc > t_acc && cyc <= t_resp)});
    if (host_resp_valid) begin
      seen_cyc  = cyc;
      seen_data = host_resp_data;
      seen_err  = host_resp_err;
    end
  end

  task automatic reset_vals(input string n);
    chk({n, "_ready"}, {31'd0, host_req_ready}, 32'd1);
    chk({n, "_rvalid"}, {31'd0, host_resp_valid}, 32'd0);
    chk({n, "_rdata"}, host_resp_data, 32'd0);
    chk({n, "_rerr"}, {31'd0, host_resp_err}, 32'd0);
    chk({n, "_pvalid"}, {24'd0, port_req_valid}, 32'd0);
    chk({n, "_pwr"}, {31'd0, port_req_wr}, 32'd0);
    chk({n, "_paddr"}, {24'd0, port_req_addr}, 32'd0);
  endtask

  // nv consecutive valid cycles on the selected port starting st cycles after accept; nv=0 means silent port
  task automatic run_txn(input logic w, input logic [3:0] p, input logic [7:0] a, input int st,
                         input int nv, input logic [31:0] b, input bit noise, input int abort_rel,
                         output int t);
    bit bc, bad;
    int rel;
    bc = p == 4'hF;
    bad = bc ? !w : p >= 4'd8;
    t = cyc;
    e_wr = w;
    e_addr = a;
    e_strobe = !bad;
    e_mask = bc ? 8'hFF : 8'h01 << p;
    t_resp = bad ? t + 2 : w ? t + 3 + WR_GAP : nv == 0 ? t + TO_CYC + 3 : t + st + nv + 1;
    e_err = bad || (!w && nv < 4);
    e_data = (!bad && !w && nv >= 4) ? b : 32'd0;
    t_acc = t;
    active = 1'b1;
    seen_cyc = -1;
    host_req_valid = 1'b1;
    host_req_wr = w;
    host_req_port = p;
    host_req_addr = a;
    while (cyc <= t_resp) begin
      @(posedge clk_if);
      #1;
      host_req_valid = 1'b0;
      rel = cyc - t;
      port_resp_valid = '0;
      port_resp_data = {$urandom, $urandom};
      if (!bad && !w && rel >= st && rel < st + nv) begin
        port_resp_valid[p[2:0]] = 1'b1;
        port_resp_data[8*p +: 8] = (rel - st < 4) ? b[31 - 8*(rel - st) -: 8] : 8'hEE;
      end
      if (noise && p != 4'd0) port_resp_valid[0] = rel[0];
      if (rel == abort_rel) begin
        #2;
        active = 1'b0;
        rst_if_n = 1'b0;
        #1;
        reset_vals("abort");
        @(posedge clk_if);
        #1;
        rst_if_n = 1'b1;
        break;
      end
    end
    port_resp_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk_if);
    #1;
    reset_vals("reset");
    rst_if_n = 1'b1;
    @(posedge clk_if);
    #1;
    run_txn(1'b0, 4'd2, 8'h00, 3, 5, 32'h12345678, 1'b0, -1, t0);
    chk("rd2_data", seen_data, 32'h12345678);
    chk("rd2_err", {31'd0, seen_err}, 32'd0);
    chk("rd2_lat", 32'(seen_cyc - t0), 32'd9);
    run_txn(1'b1, 4'd5, 8'h0F, 0, 0, 32'h0, 1'b0, -1, t0);
    chk("wr5_lat", 32'(seen_cyc - t0), 32'd7);
    chk("wr5_err", {31'd0, seen_err}, 32'd0);
    run_txn(1'b1, 4'hF, 8'h1F, 0, 0, 32'h0, 1'b0, -1, t0);
    chk("bcw_lat", 32'(seen_cyc - t0), 32'd7);
    run_txn(1'b0, 4'hF, 8'h1F, 3, 4, 32'h11223344, 1'b0, -1, t0);
    chk("bcr_err", {31'd0, seen_err}, 32'd1);
    chk("bcr_lat", 32'(seen_cyc - t0), 32'd2);
    run_txn(1'b0, 4'd9, 8'h05, 3, 4, 32'h11223344, 1'b0, -1, t0);
    chk("bad9_err", {31'd0, seen_err}, 32'd1);
    chk("bad9_lat", 32'(seen_cyc - t0), 32'd2);
    run_txn(1'b0, 4'd3, 8'h07, 0, 0, 32'h0, 1'b0, -1, t0);
    chk("to3_err", {31'd0, seen_err}, 32'd1);
    chk("to3_lat", 32'(seen_cyc - t0), 32'd67);
    run_txn(1'b0, 4'd1, 8'h22, 4, 2, 32'hDEADBEEF, 1'b1, -1, t0);
    chk("drop1_err", {31'd0, seen_err}, 32'd1);
    chk("drop1_data", seen_data, 32'd0);
    run_txn(1'b0, 4'd6, 8'h33, 5, 4, 32'hCAFE0123, 1'b1, -1, t0);
    chk("rd6_data", seen_data, 32'hCAFE0123);
    run_txn(1'b0, 4'd2, 8'h44, 3, 6, 32'h55667788, 1'b0, 5, t0);
    chk("abort_noresp", 32'(seen_cyc), 32'hFFFFFFFF);
    run_txn(1'b0, 4'd0, 8'h01, 4, 4, 32'hA1B2C3D4, 1'b0, -1, t0);
    chk("rd0_data", seen_data, 32'hA1B2C3D4);
    chk("rd0_lat", 32'(seen_cyc - t0), 32'd9);
    repeat (3) @(posedge clk_if);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
